// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared widths, FSM encoding and beat-wrap helper for mem_responder
package mem_responder_pkg;

  localparam int MEM_DATA_BITS = 128;
  localparam int MEM_ADDR_BITS = 28;
  localparam int MEM_BEATS     = 4;
  localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WDATA  = 2'd1,
    ST_RLAT   = 2'd2,
    ST_RBURST = 2'd3
  } state_t;

  // Low two address bits of burst beat n, wrapping inside the aligned group of four
  function automatic logic [1:0] wrap_beat(input logic [1:0] low, input logic [1:0] beat);
    wrap_beat = 2'(low + beat);
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/write-data/response bundle between a memory master and mem_responder
interface mem_responder_if;
  import mem_responder_pkg::*;

  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [MEM_ADDR_BITS-1:0] mem_req_addr;
  logic                     mem_req_rw;
  logic                     mem_req_data_valid;
  logic                     mem_req_data_ready;
  logic [MEM_DATA_BITS-1:0] mem_req_data_bits;
  logic [MEM_MASK_BITS-1:0] mem_req_data_mask;
  logic                     mem_resp_valid;
  logic [MEM_DATA_BITS-1:0] mem_resp_data;

  modport master (
    output mem_req_valid, mem_req_addr, mem_req_rw,
    output mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    input  mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, mem_req_rw,
    input  mem_req_data_valid, mem_req_data_bits, mem_req_data_mask,
    output mem_req_ready, mem_req_data_ready, mem_resp_valid, mem_resp_data
  );

endinterface

// File: rtl/mem_responder_array.sv
// rtl/mem_responder_array.sv - single-port byte-masked storage with a synchronous, self-clearing read register
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            idx,
  input  logic                     we,
  input  logic [MEM_MASK_BITS-1:0] wmask,
  input  logic [MEM_DATA_BITS-1:0] wdata,
  input  logic                     re,
  output logic [MEM_DATA_BITS-1:0] rdata
);

  logic [MEM_DATA_BITS-1:0] mem [DEPTH];

  // Byte-masked write; contents survive reset
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < MEM_MASK_BITS; b++) begin
        if (wmask[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  // Read register is the response data itself, so it holds zero on any cycle without a fetched beat
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[idx];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - memory responder: single-beat masked writes, four-beat wrapping read bursts
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT_LOAD = 4'(LATENCY > 1 ? LATENCY - 2 : 0);

  state_t                   state;
  logic [AW-1:0]            addr_q;
  logic [3:0]               lat_cnt;
  logic [1:0]               beat_cnt;
  logic                     req_ready_q;
  logic                     data_ready_q;
  logic                     resp_valid_q;
  logic                     req_fire;
  logic                     data_fire;
  logic [AW-1:0]            arr_idx;
  logic                     arr_we;
  logic                     arr_re;
  logic [MEM_DATA_BITS-1:0] arr_rdata;

  assign req_fire  = bus.mem_req_valid & req_ready_q;
  assign data_fire = bus.mem_req_data_valid & data_ready_q;

  assign bus.mem_req_ready      = req_ready_q;
  assign bus.mem_req_data_ready = data_ready_q;
  assign bus.mem_resp_valid     = resp_valid_q;
  assign bus.mem_resp_data      = arr_rdata;

  // Storage port control: each beat's address goes out one cycle before that beat is presented
  always_comb begin
    arr_idx = addr_q;
    arr_we  = 1'b0;
    arr_re  = 1'b0;
    case (state)
      ST_IDLE: begin
        arr_idx = bus.mem_req_addr[AW-1:0];
        arr_we  = req_fire & bus.mem_req_rw & data_fire;
        arr_re  = req_fire & ~bus.mem_req_rw & (LATENCY == 1);
      end
      ST_WDATA: begin
        arr_we = data_fire;
      end
      ST_RLAT: begin
        arr_re = (lat_cnt == 4'd0);
      end
      ST_RBURST: begin
        arr_idx = {addr_q[AW-1:2], wrap_beat(addr_q[1:0], 2'(beat_cnt + 2'd1))};
        arr_re  = (beat_cnt != 2'd3);
      end
      default: ;
    endcase
    if (reset) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  // Request FSM with registered handshake and response-valid outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      lat_cnt      <= '0;
      beat_cnt     <= '0;
      req_ready_q  <= 1'b1;
      data_ready_q <= 1'b1;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            addr_q <= bus.mem_req_addr[AW-1:0];
            if (bus.mem_req_rw) begin
              if (!data_fire) begin
                state       <= ST_WDATA;
                req_ready_q <= 1'b0;
              end
            end else begin
              req_ready_q  <= 1'b0;
              data_ready_q <= 1'b0;
              beat_cnt     <= 2'd0;
              if (LATENCY == 1) begin
                state        <= ST_RBURST;
                resp_valid_q <= 1'b1;
              end else begin
                state   <= ST_RLAT;
                lat_cnt <= LAT_LOAD;
              end
            end
          end
        end
        ST_WDATA: begin
          if (data_fire) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
          end
        end
        ST_RLAT: begin
          if (lat_cnt == 4'd0) begin
            state        <= ST_RBURST;
            resp_valid_q <= 1'b1;
            beat_cnt     <= 2'd0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        ST_RBURST: begin
          beat_cnt <= beat_cnt + 2'd1;
          if (beat_cnt == 2'd3) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            data_ready_q <= 1'b1;
          end
        end
        default: begin
          state        <= ST_IDLE;
          req_ready_q  <= 1'b1;
          data_ready_q <= 1'b1;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  mem_responder_array #(.DEPTH(DEPTH)) u_array (
    .clk   (clk),
    .reset (reset),
    .idx   (arr_idx),
    .we    (arr_we),
    .wmask (bus.mem_req_data_mask),
    .wdata (bus.mem_req_data_bits),
    .re    (arr_re),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed bench for mem_responder with a cycle-timeline reference model
module tb_mem_responder;
  import mem_responder_pkg::*;

  localparam int DEPTH = 1024;
  localparam int NCYC  = 1024;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;

  // Cycle index: cycle c is the interval following rising edge c
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if bus0();
  mem_responder_if bus1();

  mem_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
  mem_responder #(.DEPTH(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  logic         exp_v  [2][NCYC];
  logic [127:0] exp_d  [2][NCYC];
  logic         exp_r  [2][NCYC];
  logic         exp_dr [2][NCYC];
  logic [127:0] mdl    [2][DEPTH];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int lat(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic logic rd_valid(input int d);
    return (d == 0) ? bus0.mem_resp_valid : bus1.mem_resp_valid;
  endfunction

  function automatic logic rd_ready(input int d);
    return (d == 0) ? bus0.mem_req_ready : bus1.mem_req_ready;
  endfunction

  function automatic logic [127:0] rd_data(input int d);
    return (d == 0) ? bus0.mem_resp_data : bus1.mem_resp_data;
  endfunction

  // From cycle c on, both responders are expected idle and ready
  function automatic void set_idle_from(input int c);
    for (int d = 0; d < 2; d++) begin
      for (int t = c; t < NCYC; t++) begin
        exp_v[d][t]  = 1'b0;
        exp_d[d][t]  = '0;
        exp_r[d][t]  = 1'b1;
        exp_dr[d][t] = 1'b1;
      end
    end
  endfunction

  function automatic void mdl_write(input int d, input logic [27:0] a, input logic [127:0] data,
                                    input logic [15:0] mask);
    int e;
    e = int'(a) % DEPTH;
    for (int b = 0; b < 16; b++) begin
      if (mask[b]) mdl[d][e][8*b +: 8] = data[8*b +: 8];
    end
  endfunction

  task automatic drive(input int d, input logic v, input logic rw, input logic [27:0] a,
                       input logic dv, input logic [127:0] data, input logic [15:0] m);
    if (d == 0) begin
      bus0.mem_req_valid = v;  bus0.mem_req_rw = rw; bus0.mem_req_addr = a;
      bus0.mem_req_data_valid = dv; bus0.mem_req_data_bits = data; bus0.mem_req_data_mask = m;
    end else begin
      bus1.mem_req_valid = v;  bus1.mem_req_rw = rw; bus1.mem_req_addr = a;
      bus1.mem_req_data_valid = dv; bus1.mem_req_data_bits = data; bus1.mem_req_data_mask = m;
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_write(input int d, input logic [27:0] a, input logic [127:0] data,
                          input logic [15:0] m);
    drive(d, 1'b1, 1'b1, a, 1'b1, data, m);
    mdl_write(d, a, data, m);
    step();
    drive(d, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Write request first, data gap cycles later; request side stalls until the data lands
  task automatic do_write_split(input int d, input logic [27:0] a, input logic [127:0] data,
                                input logic [15:0] m, input int gap);
    int c;
    c = cyc;
    for (int t = c + 1; t <= c + gap; t++) exp_r[d][t] = 1'b0;
    drive(d, 1'b1, 1'b1, a, 1'b0, '0, '0);
    step();
    drive(d, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    check("wdata_ready_low", rd_ready(d), 1'b0);
    step(gap - 1);
    drive(d, 1'b0, 1'b0, '0, 1'b1, data, m);
    mdl_write(d, a, data, m);
    step();
    drive(d, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  // Read accepted in the current cycle c: beats at c+L..c+L+3, request side busy until c+L+4
  task automatic do_read(input int d, input logic [27:0] a);
    int c, l, ai, grp, e;
    c  = cyc;
    l  = lat(d);
    ai = int'(a);
    grp = ai - (ai % 4);
    for (int i = 0; i < 4; i++) begin
      e = (grp + ((ai % 4 + i) % 4)) % DEPTH;
      exp_v[d][c + l + i] = 1'b1;
      exp_d[d][c + l + i] = mdl[d][e];
    end
    for (int t = c + 1; t <= c + l + 3; t++) begin
      exp_r[d][t]  = 1'b0;
      exp_dr[d][t] = 1'b0;
    end
    drive(d, 1'b1, 1'b0, a, 1'b0, '0, '0);
    step();
    drive(d, 1'b0, 1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    set_idle_from(cyc + 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic prefill(input int d, input int base, input int n, input bit zero);
    for (int i = 0; i < n; i++) begin
      do_write(d, 28'(base + i), zero ? 128'h0 : {4{32'h1000_0000 + 32'(base + i)}}, 16'hFFFF);
    end
  endtask

  // Every cycle: outputs of both responders against the model timeline
  always @(negedge clk) begin
    if (chk_en && cyc < NCYC) begin
      check("d0_resp_valid", bus0.mem_resp_valid,     exp_v[0][cyc]);
      check("d0_resp_data",  bus0.mem_resp_data,      exp_d[0][cyc]);
      check("d0_req_ready",  bus0.mem_req_ready,      exp_r[0][cyc]);
      check("d0_data_ready", bus0.mem_req_data_ready, exp_dr[0][cyc]);
      check("d1_resp_valid", bus1.mem_resp_valid,     exp_v[1][cyc]);
      check("d1_resp_data",  bus1.mem_resp_data,      exp_d[1][cyc]);
      check("d1_req_ready",  bus1.mem_req_ready,      exp_r[1][cyc]);
      check("d1_data_ready", bus1.mem_req_data_ready, exp_dr[1][cyc]);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    set_idle_from(0);
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    step(3);
    reset  = 1'b0;
    chk_en = 1'b1;

    check("rst_req_ready",  bus0.mem_req_ready, 1'b1);
    check("rst_data_ready", bus0.mem_req_data_ready, 1'b1);
    check("rst_resp_valid", bus0.mem_resp_valid, 1'b0);
    check("rst_resp_data",  bus0.mem_resp_data, 128'h0);

    // Full-mask write then read at LATENCY=2
    prefill(0, 'h10, 4, 1'b0);
    do_write(0, 28'h10, 128'h00112233_44556677_8899AABB_CCDDEEFF, 16'hFFFF);
    do_read(0, 28'h10);
    check("s1_valid_k1", rd_valid(0), 1'b0);
    step();
    check("s1_valid_k2", rd_valid(0), 1'b1);
    check("s1_beat0", rd_data(0), 128'h00112233_44556677_8899AABB_CCDDEEFF);
    step(3);
    check("s1_valid_k5", rd_valid(0), 1'b1);
    check("s1_ready_k5", rd_ready(0), 1'b0);
    step();
    check("s1_ready_k6", rd_ready(0), 1'b1);
    check("s1_valid_k6", rd_valid(0), 1'b0);

    // Upper address bits alias onto the same entry
    do_write(0, 28'h410, 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0, 16'hFFFF);
    do_read(0, 28'h10);
    step();
    check("alias_beat0", rd_data(0), 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0);
    step(4);

    // Single-byte mask over a zero entry
    prefill(0, 'h4, 4, 1'b1);
    do_write(0, 28'h5, {128{1'b1}}, 16'h0001);
    do_read(0, 28'h4);
    step(2);
    check("s2_beat1", rd_data(0), 128'h0000_00FF);
    step(3);

    // Wrapping burst order from a misaligned start
    for (int i = 4; i < 8; i++) do_write(0, 28'(i), 128'(i), 16'hFFFF);
    do_read(0, 28'h7);
    step();
    check("s3_beat0", rd_data(0), 128'd7);
    step();
    check("s3_beat1", rd_data(0), 128'd4);
    step();
    check("s3_beat2", rd_data(0), 128'd5);
    step();
    check("s3_beat3", rd_data(0), 128'd6);
    step();

    // Deferred write data with partial mask, then a lone data beat that must be dropped
    prefill(0, 'h30, 4, 1'b1);
    do_write_split(0, 28'h31, {16{8'hA5}}, 16'hF0F0, 3);
    drive(0, 1'b0, 1'b0, 28'h31, 1'b1, {128{1'b1}}, 16'hFFFF);
    step();
    drive(0, 1'b0, 1'b0, '0, 1'b0, '0, '0);
    do_read(0, 28'h30);
    step(2);
    check("s4_beat1", rd_data(0), 128'hA5A5A5A5_00000000_A5A5A5A5_00000000);
    step(3);

    // Reset during beat 1 aborts the burst; storage survives
    do_read(0, 28'h10);
    step(2);
    check("s5_beat1_valid", rd_valid(0), 1'b1);
    do_reset();
    check("s5_valid_after_rst", rd_valid(0), 1'b0);
    check("s5_ready_after_rst", rd_ready(0), 1'b1);
    check("s5_data_after_rst",  rd_data(0), 128'h0);
    step(5);
    do_read(0, 28'h10);
    step();
    check("s5_reread_beat0", rd_data(0), 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0);
    step(4);

    // LATENCY=1, back-to-back bursts
    prefill(1, 'h20, 8, 1'b0);
    do_read(1, 28'h22);
    check("s6_a_valid_k1", rd_valid(1), 1'b1);
    check("s6_a_beat0", rd_data(1), 128'h10000022_10000022_10000022_10000022);
    step(3);
    check("s6_a_valid_k4", rd_valid(1), 1'b1);
    check("s6_a_ready_k4", rd_ready(1), 1'b0);
    step();
    check("s6_ready_k5", rd_ready(1), 1'b1);
    check("s6_valid_k5", rd_valid(1), 1'b0);
    do_read(1, 28'h24);
    check("s6_b_beat0", rd_data(1), 128'h10000024_10000024_10000024_10000024);
    step();
    check("s6_b_beat1", rd_data(1), 128'h10000025_10000025_10000025_10000025);
    step(2);
    check("s6_b_valid_k9", rd_valid(1), 1'b1);
    step();
    check("s6_b_valid_k10", rd_valid(1), 1'b0);
    check("s6_b_ready_k10", rd_ready(1), 1'b1);

    step(3);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
